// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encoding and Q3.(dw-3) CORDIC constants derived from a 2^30-scaled master table
package cordic_pkg;
  typedef enum logic {MODE_ROT = 1'b0, MODE_VEC = 1'b1} mode_e;
  localparam logic [63:0] PI30 = 64'd3373259426;
  localparam logic [63:0] HALF_PI30 = 64'd1686629713;
  localparam logic [63:0] K30 = 64'd652032874;
  localparam logic [0:31][31:0] ATAN30 = {
    32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6, 32'h03FEAB76, 32'h01FFD55B,
    32'h00FFFAAA, 32'h007FFF55, 32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
    32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF, 32'h00003FFF, 32'h00001FFF,
    32'h00000FFF, 32'h000007FF, 32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
    32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008, 32'h00000004, 32'h00000002,
    32'h00000001, 32'h00000000};
  // Round a 2^30-scaled constant to dw-3 fractional bits (dw <= 32)
  function automatic logic [31:0] q3(int dw, logic [63:0] v);
    return 32'((v + (64'd1 << (32 - dw))) >> (33 - dw));
  endfunction
  function automatic logic [31:0] pi_q(int dw);
    return q3(dw, PI30);
  endfunction
  function automatic logic [31:0] half_pi_q(int dw);
    return q3(dw, HALF_PI30);
  endfunction
  function automatic logic [31:0] k_q(int dw);
    return q3(dw, K30);
  endfunction
  function automatic logic [31:0] atan_q(int dw, int i);
    return q3(dw, 64'(ATAN30[i]));
  endfunction
endpackage

// File: rtl/cordic_fifo.sv
// cordic_fifo: show-ahead synchronous FIFO with registered full/empty
module cordic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic wr, rd;
  assign wr = wr_en & ~full;
  assign rd = rd_en & ~empty;
  assign cnt_n = cnt + (AW+1)'(wr) - (AW+1)'(rd);
  // Head is forced to zero while empty so stale storage never shows
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
endmodule

// File: rtl/cordic_engine.sv
// cordic_engine: FIFO-wrapped, credit-controlled, fully pipelined CORDIC (rotation or vectoring per sample)
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STAGES = 16,
  parameter int IN_DEPTH = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_wr_en,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_z,
  output logic              in_full,
  input  logic              out_rd_en,
  output logic              out_empty,
  output logic              out_mode,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_z
);
  localparam int PW = 3*DATA_W + 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic signed [DATA_W-1:0] PI = DATA_W'(pi_q(DATA_W));
  localparam logic signed [DATA_W-1:0] HALF_PI = DATA_W'(half_pi_q(DATA_W));
  logic [PW-1:0] in_data, out_data;
  logic in_empty, out_full, pop, drain, flip, sub;
  logic [CW-1:0] credit;
  logic pv;
  mode_e pm;
  logic signed [DATA_W-1:0] px, py, pz, zadj;
  logic sv [STAGES+1];
  mode_e sm [STAGES+1];
  logic signed [DATA_W-1:0] sx [STAGES+1];
  logic signed [DATA_W-1:0] sy [STAGES+1];
  logic signed [DATA_W-1:0] sz [STAGES+1];
  cordic_fifo #(.WIDTH(PW), .DEPTH(IN_DEPTH)) u_in (
    .clk, .reset, .wr_en(in_wr_en), .wr_data({in_mode, in_x, in_y, in_z}), .full(in_full),
    .rd_en(pop), .rd_data(in_data), .empty(in_empty));
  // Credit covers every slot the output FIFO may eventually need, so the pipeline never stalls
  assign pop = ~in_empty && credit < CW'(OUT_DEPTH);
  assign drain = out_rd_en & ~out_empty;
  assign flip = (pm == MODE_ROT) ? (pz > HALF_PI || pz < -HALF_PI) : px[DATA_W-1];
  assign sub = (pm == MODE_ROT) ? pz > HALF_PI : py[DATA_W-1];
  assign zadj = sub ? pz - PI : pz + PI;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      credit <= '0;
      pv <= 1'b0;
      pm <= MODE_ROT;
      px <= '0;
      py <= '0;
      pz <= '0;
      sv[0] <= 1'b0;
      sm[0] <= MODE_ROT;
      sx[0] <= '0;
      sy[0] <= '0;
      sz[0] <= '0;
    end else begin
      credit <= credit + CW'(pop) - CW'(drain);
      pv <= pop;
      pm <= mode_e'(in_data[PW-1]);
      px <= in_data[3*DATA_W-1 -: DATA_W];
      py <= in_data[2*DATA_W-1 -: DATA_W];
      pz <= in_data[DATA_W-1:0];
      sv[0] <= pv;
      sm[0] <= pm;
      sx[0] <= flip ? -px : px;
      sy[0] <= flip ? -py : py;
      sz[0] <= flip ? zadj : pz;
    end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam logic signed [DATA_W-1:0] AT = DATA_W'(atan_q(DATA_W, i));
    logic pos;
    assign pos = (sm[i] == MODE_ROT) ? ~sz[i][DATA_W-1] : sy[i][DATA_W-1];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sv[i+1] <= 1'b0;
        sm[i+1] <= MODE_ROT;
        sx[i+1] <= '0;
        sy[i+1] <= '0;
        sz[i+1] <= '0;
      end else begin
        sv[i+1] <= sv[i];
        sm[i+1] <= sm[i];
        sx[i+1] <= pos ? sx[i] - (sy[i] >>> i) : sx[i] + (sy[i] >>> i);
        sy[i+1] <= pos ? sy[i] + (sx[i] >>> i) : sy[i] - (sx[i] >>> i);
        sz[i+1] <= pos ? sz[i] - AT : sz[i] + AT;
      end
  end
  cordic_fifo #(.WIDTH(PW), .DEPTH(OUT_DEPTH)) u_out (
    .clk, .reset, .wr_en(sv[STAGES] & ~out_full),
    .wr_data({sm[STAGES], sx[STAGES], sy[STAGES], sz[STAGES]}), .full(out_full),
    .rd_en(out_rd_en), .rd_data(out_data), .empty(out_empty));
  assign out_mode = out_data[PW-1];
  assign out_x = out_data[3*DATA_W-1 -: DATA_W];
  assign out_y = out_data[2*DATA_W-1 -: DATA_W];
  assign out_z = out_data[DATA_W-1:0];
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: randomized scoreboard bench comparing cordic_engine to a loop-level CORDIC model
module tb_cordic_engine;
  localparam int N = 16;
  localparam logic signed [15:0] PI = 16'sd25736, HP = 16'sd12868;
  typedef struct packed { logic m; logic [15:0] x, y, z; } res_t;
  logic clk = 0, reset = 1, in_wr_en = 0, in_mode = 0, out_rd_en = 0;
  logic in_full, out_empty, out_mode;
  logic [15:0] in_x = 0, in_y = 0, in_z = 0, out_x, out_y, out_z;
  int tests = 0, fails = 0, rd_policy = 0, n_pop = 0, max_credit = 0;
  res_t exp_q[$];
  logic signed [15:0] at [N];

  cordic_engine dut (
    .clk(clk), .reset(reset), .in_wr_en(in_wr_en), .in_mode(in_mode), .in_x(in_x), .in_y(in_y),
    .in_z(in_z), .in_full(in_full), .out_rd_en(out_rd_en), .out_empty(out_empty),
    .out_mode(out_mode), .out_x(out_x), .out_y(out_y), .out_z(out_z));

  always #5 clk = ~clk;

  function automatic res_t model(logic m, logic [15:0] xi, logic [15:0] yi, logic [15:0] zi);
    logic signed [15:0] x, y, z, t;
    logic pos;
    x = xi;
    y = yi;
    z = zi;
    if (!m && (z > HP || z < -HP)) begin
      z = (z > HP) ? z - PI : z + PI;
      x = -x;
      y = -y;
    end else if (m && x < 0) begin
      z = (y >= 0) ? z + PI : z - PI;
      x = -x;
      y = -y;
    end
    for (int i = 0; i < N; i++) begin
      pos = m ? (y < 0) : (z >= 0);
      t = x;
      x = pos ? x - (y >>> i) : x + (y >>> i);
      y = pos ? y + (t >>> i) : y - (t >>> i);
      z = pos ? z - at[i] : z + at[i];
    end
    return '{m, x, y, z};
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(string name, logic [15:0] act, logic [15:0] exp);
    int d;
    d = int'($signed(act)) - int'($signed(exp));
    tests++;
    if (d > 4 || d < -4) begin
      fails++;
      $display("FAIL %s: got %h want %h (+-4)", name, act, exp);
    end
  endtask

  task automatic push(logic m, logic [15:0] x, logic [15:0] y, logic [15:0] z);
    int t = 0;
    @(negedge clk);
    in_wr_en = 1;
    in_mode = m;
    in_x = x;
    in_y = y;
    in_z = z;
    while (in_full && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("push timeout", 1, 0);
    @(posedge clk);
    exp_q.push_back(model(m, x, y, z));
    #1 in_wr_en = 0;
  endtask

  function automatic logic [15:0] rs(int a);
    return 16'(int'($urandom_range(0, 2*a)) - a);
  endfunction

  task automatic push_rand();
    if ($urandom_range(0, 1) == 0) push(0, rs(4096), rs(4096), rs(25736));
    else push(1, rs(6144), rs(6144), rs(1024));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || !out_empty) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain queue", exp_q.size(), 0);
    chk("drain out_empty", out_empty, 1);
  endtask

  always @(negedge clk) begin
    if (reset) out_rd_en = 0;
    else begin
      out_rd_en = rd_policy == 1 || (rd_policy == 2 && $urandom_range(0, 2) != 0);
      if (dut.credit > max_credit) max_credit = dut.credit;
      if (!out_empty) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected output: got m=%b x=%h y=%h z=%h want none", out_mode, out_x, out_y, out_z);
        end else if ({out_mode, out_x, out_y, out_z} != exp_q[0]) begin
          fails++;
          $display("FAIL head #%0d: got m=%b x=%h y=%h z=%h want m=%b x=%h y=%h z=%h", n_pop,
                   out_mode, out_x, out_y, out_z, exp_q[0].m, exp_q[0].x, exp_q[0].y, exp_q[0].z);
        end
        if (out_rd_en && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    res_t r;
    int lat, t, base;
    for (int i = 0; i < N; i++) at[i] = 16'($rtoi($atan(1.0 / (2.0 ** i)) * 8192.0 + 0.5));
    r = model(0, 16'h136F, 16'h0000, 16'h0000);
    chk_tol("model cos0 x", r.x, 16'h2000);
    chk_tol("model cos0 y", r.y, 16'h0000);
    r = model(0, 16'h136F, 16'h0000, 16'h3244);
    chk_tol("model rot90 x", r.x, 16'h0000);
    chk_tol("model rot90 y", r.y, 16'h2000);
    r = model(0, 16'h136F, 16'h0000, 16'h6488);
    chk_tol("model rot180 x", r.x, 16'hE000);
    chk_tol("model rot180 y", r.y, 16'h0000);
    r = model(1, 16'h2000, 16'h2000, 16'h0000);
    chk_tol("model vec45 z", r.z, 16'h1922);
    chk_tol("model vec45 x", r.x, 16'h4A87);
    r = model(1, 16'hE000, 16'h0000, 16'h0000);
    chk_tol("model vec180 z", r.z, 16'h6488);
    repeat (2) @(negedge clk);
    chk("reset in_full", in_full, 0);
    chk("reset out_empty", out_empty, 1);
    chk("reset outputs zero", {out_mode, out_x, out_y, out_z} == '0, 1);
    @(negedge clk);
    #2 reset = 0;
    push(0, 16'h136F, 16'h0000, 16'h0000);
    lat = 0;
    while (out_empty && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, N + 3);
    push(0, 16'h136F, 16'h0000, 16'h3244);
    push(0, 16'h136F, 16'h0000, 16'h6488);
    push(1, 16'h2000, 16'h2000, 16'h0000);
    push(1, 16'hE000, 16'h0000, 16'h0000);
    rd_policy = 1;
    wait_drain();
    rd_policy = 0;
    base = n_pop;
    max_credit = 0;
    fork
      for (int k = 0; k < 40; k++) push_rand();
    join_none
    t = 0;
    while (!in_full && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("backpressure in_full", in_full, 1);
    repeat (10) @(negedge clk);
    chk("credit peak", max_credit, 16);
    rd_policy = 1;
    wait fork;
    wait_drain();
    chk("backpressure count", n_pop - base, 40);
    rd_policy = 0;
    for (int k = 0; k < 10; k++) push_rand();
    repeat (N + 6) @(negedge clk);
    chk("pre-reset out_empty", out_empty, 0);
    #2 reset = 1;
    #1;
    chk("mid reset out_empty", out_empty, 1);
    chk("mid reset in_full", in_full, 0);
    exp_q.delete();
    @(posedge clk);
    #2 reset = 0;
    rd_policy = 1;
    base = n_pop;
    for (int k = 0; k < 3; k++) push_rand();
    wait_drain();
    chk("post reset count", n_pop - base, 3);
    rd_policy = 2;
    base = n_pop;
    for (int k = 0; k < 150; k++) push_rand();
    wait_drain();
    chk("random count", n_pop - base, 150);
    chk("credit bound", max_credit <= 16, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
